// File: rtl/prirv32_idu.sv
// rtl/prirv32_idu.sv - priRV32 instruction decode stage
// Decodes one RV32I instruction per handshake into a single registered stage feeding execute.
module prirv32_idu #(
   parameter int ILLEGAL_HALT = 1
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        ifu_valid_i,
   input  logic [31:0] ifu_inst_i,
   input  logic [31:0] ifu_pc_i,
   output logic        idu_ready_o,
   input  logic        exu_ready_i,
   input  logic        exu_flush_i,
   output logic        idu_valid_o,
   output logic [31:0] pc_o,
   output logic [4:0]  rs1_addr_o,
   output logic [4:0]  rs2_addr_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] imm_o,
   output logic [2:0]  funct3_o,
   output logic [3:0]  alu_op_o,
   output logic        use_imm_o,
   output logic        rd_we_o,
   output logic        is_branch_o,
   output logic        is_jal_o,
   output logic        is_jalr_o,
   output logic        is_load_o,
   output logic        is_store_o,
   output logic        is_auipc_o,
   output logic        illegal_o
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   state_t      state;
   state_t      state_nxt;
   logic        accept;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic [31:0] dec_imm;
   logic [3:0]  dec_alu;
   logic        dec_use_imm;
   logic        dec_rd_we;
   logic        dec_branch;
   logic        dec_jal;
   logic        dec_jalr;
   logic        dec_load;
   logic        dec_store;
   logic        dec_auipc;
   logic        dec_illegal;

   assign opcode = ifu_inst_i[6:0];
   assign funct3 = ifu_inst_i[14:12];
   assign funct7 = ifu_inst_i[31:25];

   assign imm_i = {{20{ifu_inst_i[31]}}, ifu_inst_i[31:20]};
   assign imm_s = {{20{ifu_inst_i[31]}}, ifu_inst_i[31:25], ifu_inst_i[11:7]};
   assign imm_b = {{19{ifu_inst_i[31]}}, ifu_inst_i[31], ifu_inst_i[7],
                   ifu_inst_i[30:25], ifu_inst_i[11:8], 1'b0};
   assign imm_u = {ifu_inst_i[31:12], 12'b0};
   assign imm_j = {{11{ifu_inst_i[31]}}, ifu_inst_i[31], ifu_inst_i[19:12],
                   ifu_inst_i[20], ifu_inst_i[30:21], 1'b0};

   // alt selects SUB/SRA; callers only raise it where that encoding exists
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      dec_rs1     = 5'd0;
      dec_rs2     = 5'd0;
      dec_rd      = 5'd0;
      dec_imm     = 32'd0;
      dec_alu     = ALU_ADD;
      dec_use_imm = 1'b0;
      dec_rd_we   = 1'b0;
      dec_branch  = 1'b0;
      dec_jal     = 1'b0;
      dec_jalr    = 1'b0;
      dec_load    = 1'b0;
      dec_store   = 1'b0;
      dec_auipc   = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         OP_R: begin
            dec_rs1     = ifu_inst_i[19:15];
            dec_rs2     = ifu_inst_i[24:20];
            dec_rd      = ifu_inst_i[11:7];
            dec_rd_we   = 1'b1;
            dec_alu     = alu_from_f3(funct3, funct7[5]);
            dec_illegal = !((funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OP_IMM: begin
            dec_rs1     = ifu_inst_i[19:15];
            dec_rd      = ifu_inst_i[11:7];
            dec_imm     = imm_i;
            dec_use_imm = 1'b1;
            dec_rd_we   = 1'b1;
            dec_alu     = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
         end
         OP_LOAD: begin
            dec_rs1     = ifu_inst_i[19:15];
            dec_rd      = ifu_inst_i[11:7];
            dec_imm     = imm_i;
            dec_use_imm = 1'b1;
            dec_rd_we   = 1'b1;
            dec_load    = 1'b1;
         end
         OP_STORE: begin
            dec_rs1     = ifu_inst_i[19:15];
            dec_rs2     = ifu_inst_i[24:20];
            dec_imm     = imm_s;
            dec_use_imm = 1'b1;
            dec_store   = 1'b1;
         end
         OP_BRANCH: begin
            dec_rs1     = ifu_inst_i[19:15];
            dec_rs2     = ifu_inst_i[24:20];
            dec_imm     = imm_b;
            dec_alu     = ALU_SUB;
            dec_branch  = 1'b1;
         end
         OP_JAL: begin
            dec_rd      = ifu_inst_i[11:7];
            dec_imm     = imm_j;
            dec_rd_we   = 1'b1;
            dec_jal     = 1'b1;
         end
         OP_JALR: begin
            dec_rs1     = ifu_inst_i[19:15];
            dec_rd      = ifu_inst_i[11:7];
            dec_imm     = imm_i;
            dec_rd_we   = 1'b1;
            dec_jalr    = 1'b1;
            dec_illegal = (funct3 != 3'b000);
         end
         OP_LUI: begin
            dec_rd      = ifu_inst_i[11:7];
            dec_imm     = imm_u;
            dec_alu     = ALU_PASSB;
            dec_use_imm = 1'b1;
            dec_rd_we   = 1'b1;
         end
         OP_AUIPC: begin
            dec_rd      = ifu_inst_i[11:7];
            dec_imm     = imm_u;
            dec_rd_we   = 1'b1;
            dec_auipc   = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      // an illegal word carries only its PC, funct3 and the illegal flag downstream
      if (dec_illegal) begin
         dec_rs1     = 5'd0;
         dec_rs2     = 5'd0;
         dec_rd      = 5'd0;
         dec_imm     = 32'd0;
         dec_alu     = ALU_ADD;
         dec_use_imm = 1'b0;
         dec_rd_we   = 1'b0;
         dec_branch  = 1'b0;
         dec_jal     = 1'b0;
         dec_jalr    = 1'b0;
         dec_load    = 1'b0;
         dec_store   = 1'b0;
         dec_auipc   = 1'b0;
      end
   end

   assign idu_ready_o = (state == ST_RUN) && (!idu_valid_o || exu_ready_i);
   assign accept      = ifu_valid_i && idu_ready_o && !exu_flush_i;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (exu_flush_i) begin
         state_nxt = ST_RUN;
      end else if (accept && dec_illegal && (ILLEGAL_HALT != 0)) begin
         state_nxt = ST_HALT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         idu_valid_o <= 1'b0;
         pc_o        <= 32'd0;
         rs1_addr_o  <= 5'd0;
         rs2_addr_o  <= 5'd0;
         rd_addr_o   <= 5'd0;
         imm_o       <= 32'd0;
         funct3_o    <= 3'd0;
         alu_op_o    <= 4'd0;
         use_imm_o   <= 1'b0;
         rd_we_o     <= 1'b0;
         is_branch_o <= 1'b0;
         is_jal_o    <= 1'b0;
         is_jalr_o   <= 1'b0;
         is_load_o   <= 1'b0;
         is_store_o  <= 1'b0;
         is_auipc_o  <= 1'b0;
         illegal_o   <= 1'b0;
      end else if (exu_flush_i) begin
         idu_valid_o <= 1'b0;
      end else if (accept) begin
         idu_valid_o <= 1'b1;
         pc_o        <= ifu_pc_i;
         rs1_addr_o  <= dec_rs1;
         rs2_addr_o  <= dec_rs2;
         rd_addr_o   <= dec_rd;
         imm_o       <= dec_imm;
         funct3_o    <= funct3;
         alu_op_o    <= dec_alu;
         use_imm_o   <= dec_use_imm;
         rd_we_o     <= dec_rd_we && (dec_rd != 5'd0);
         is_branch_o <= dec_branch;
         is_jal_o    <= dec_jal;
         is_jalr_o   <= dec_jalr;
         is_load_o   <= dec_load;
         is_store_o  <= dec_store;
         is_auipc_o  <= dec_auipc;
         illegal_o   <= dec_illegal;
      end else if (idu_valid_o && exu_ready_i) begin
         idu_valid_o <= 1'b0;
      end
   end

endmodule

// File: doc/prirv32_idu.md
# prirv32_idu

Instruction decode unit (IDU) for the priRV32 core. It sits directly downstream of the instruction fetch unit and accepts one 32-bit RV32I instruction plus its PC per handshake. It decodes register indices, the sign-extended immediate and the ALU/control class into a single registered pipeline stage that feeds the execute unit. A branch-taken flush from execute discards the in-flight instruction.

## Interface
Parameters:
- ILLEGAL_HALT, default 1: if 1, an illegal instruction parks the stage in HALT until a flush; if 0, the instruction is passed downstream with illegal_o=1 and decoding continues.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ifu_valid_i  in  1  fetch has an instruction on ifu_inst_i/ifu_pc_i.
- ifu_inst_i  in  32  raw instruction word.
- ifu_pc_i  in  32  address of ifu_inst_i.
- idu_ready_o  out  1  IDU can accept this cycle.
- exu_ready_i  in  1  execute accepts the decoded instruction.
- exu_flush_i  in  1  branch/jump taken in execute; kill the IDU contents.
- idu_valid_o  out  1  decoded outputs are valid.
- pc_o  out  32  PC of the decoded instruction.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register indices (0 when the format has no such field).
- imm_o  out  32  sign-extended immediate (0 for R-type).
- funct3_o  out  3  inst[14:12], passed through for branch/load/store width.
- alu_op_o  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- use_imm_o, rd_we_o, is_branch_o, is_jal_o, is_jalr_o, is_load_o, is_store_o, is_auipc_o  out  1 each  control flags.
- illegal_o  out  1  opcode/funct combination not in RV32I base.

## Operation
- Accept condition: ifu_valid_i && idu_ready_o && !exu_flush_i. On accept, decode combinationally and load all outputs into the stage register; idu_valid_o=1.
- idu_ready_o = (state==RUN) && (!idu_valid_o || exu_ready_i).
- Handshake out: when idu_valid_o && exu_ready_i and no new accept occurs, idu_valid_o clears. If both occur, the new instruction replaces the old in the same edge.
- Immediates: I = {{20{i[31]}}, i[31:20]}; S = {{20{i[31]}}, i[31:25], i[11:7]}; B = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; U = {i[31:12], 12'b0}; J = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
- Opcode map: 0110011 R (alu from funct3/funct7[5]); 0010011 I-ALU (use_imm; SRAI when funct7[5]=1; SUB is not encodable); 0000011 load (ADD, use_imm, rd_we); 0100011 store (ADD, use_imm); 1100011 branch (SUB, is_branch, rd_we=0); 1101111 JAL; 1100111 JALR (funct3 must be 000); 0110111 LUI (PASSB, use_imm); 0010111 AUIPC (ADD, is_auipc).
- rd_we_o is forced 0 when rd_addr_o==0.
- All other opcodes, and R-type funct7 not in {0000000, 0100000 for SUB/SRA}, set illegal_o=1 and clear every other control flag.
- FSM: RUN -> HALT on accepting an illegal instruction when ILLEGAL_HALT=1. HALT -> RUN only on exu_flush_i. In HALT, idu_ready_o=0 and the illegal instruction stays presented until exu_ready_i consumes it.

## Timing
- Latency: 1 cycle from accept to idu_valid_o.
- Reset (async, rst_n=0): state=RUN; idu_valid_o=0; all data and control outputs 0; idu_ready_o=1 once reset deasserts.
- exu_flush_i has priority over everything. At the next edge idu_valid_o=0 and state=RUN. The fetch offered in the same cycle is dropped, even though idu_ready_o may read 1.
- Stall: while idu_valid_o && !exu_ready_i, all outputs hold bit-exact.
- Reset asserted mid-stream clears the stage immediately (asynchronously); no partial instruction survives.

## Test plan
- Reset then BEQ 0x0432_8863 (0000010_00011_00101_000_10000_1100011) at PC 0x8000_0000 -> next cycle: idu_valid_o=1, rs1=5, rs2=3, imm=0x0000_0050, is_branch=1, alu_op=SUB, rd_we=0, pc_o=0x8000_0000.
- ADDI x1,x0,-1 (0xFFF0_0093) then LUI x2,0x12345 (0x1234_5137) back-to-back with exu_ready_i=1 -> imm 0xFFFF_FFFF/ADD/use_imm/rd=1, then imm 0x1234_5000/PASSB/rd=2 on consecutive cycles.
- exu_ready_i=0 for 3 cycles with the stage full -> idu_ready_o=0 and outputs unchanged; exu_ready_i=1 -> the next instruction is accepted in the same cycle.
- exu_flush_i=1 together with ifu_valid_i=1 -> idu_valid_o=0 on the next cycle and the offered instruction never appears.
- 0x0000_0000 with ILLEGAL_HALT=1 -> illegal_o=1, idu_ready_o stays 0 across 5 cycles; exu_flush_i -> returns to RUN and idu_ready_o=1.
- rst_n pulsed low mid-stall -> all outputs 0 asynchronously, before the next clock edge.
